// File: rtl/evo_circuit_tester.sv
// evo_circuit_tester: drives a 2-bit stimulus into an asynchronous circuit under test,
// samples its synchronized output per vector and accumulates match / unstable counts.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse that begins a run (ignored unless idle)
//   vec_addr/vec_data stimulus table address / word {expected, input[1:0]}
//   dut_in/dut_out    registered drive to, and asynchronous output from, the circuit
//   busy/done         run in progress / run complete
//   score/unstable    vectors that matched stably / vectors whose samples disagreed
module evo_circuit_tester #(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int IW            = $clog2(NUM_VECTORS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [IW-1:0] vec_addr,
    input  logic [2:0]    vec_data,
    output logic [1:0]    dut_in,
    input  logic          dut_out,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] score,
    output logic [IW-1:0] unstable
);
    localparam int CW = $clog2((SETTLE_CYCLES > SAMPLE_CYCLES ? SETTLE_CYCLES : SAMPLE_CYCLES) + 1);

    typedef enum logic [2:0] {IDLE, FETCH, APPLY, SETTLE, SAMPLE, DONE} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          sync_q;
    logic          exp_q;
    logic          ref_q;
    logic          unst;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          last_smp;
    logic          r_now;
    logic          u_now;

    assign sync_q   = sync[1];
    assign last_smp = cnt == CW'(SAMPLE_CYCLES - 1);
    // Classification folds in the current cycle's sample so the last sample counts too.
    assign r_now    = cnt == '0 ? sync_q : ref_q;
    assign u_now    = unst | (cnt != '0 && sync_q != ref_q);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else sync <= {sync[0], dut_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec_addr <= '0;
            dut_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            score    <= '0;
            unstable <= '0;
            exp_q    <= 1'b0;
            ref_q    <= 1'b0;
            unst     <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    score    <= '0;
                    unstable <= '0;
                    idx      <= '0;
                    vec_addr <= '0;
                    done     <= 1'b0;
                    busy     <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    vec_addr <= idx;
                    state    <= APPLY;
                end
                APPLY: begin
                    dut_in <= vec_data[1:0];
                    exp_q  <= vec_data[2];
                    cnt    <= '0;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    cnt <= cnt == CW'(SETTLE_CYCLES - 1) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(SETTLE_CYCLES - 1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (cnt == '0) begin
                        ref_q <= sync_q;
                        unst  <= 1'b0;
                    end else if (sync_q != ref_q) unst <= 1'b1;
                    cnt <= cnt + 1'b1;
                    if (last_smp) begin
                        if (u_now) unstable <= unstable + 1'b1;
                        else if (r_now == exp_q) score <= score + 1'b1;
                        cnt <= '0;
                        if (idx == IW'(NUM_VECTORS - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Address moves now so the table word is ready by APPLY.
                            idx      <= idx + 1'b1;
                            vec_addr <= idx + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_evo_circuit_tester.sv
// tb_evo_circuit_tester: directed self-checking bench for evo_circuit_tester (4 vectors).
module tb_evo_circuit_tester;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] vec_addr;
    logic [2:0] vec_data = 3'b000;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [2:0] score;
    logic [2:0] unstable;

    logic [2:0] rom [4];
    logic       tog = 1'b0;
    int         mode = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] seen [4];
    logic       acc_done, acc_busy;
    logic [2:0] acc_score, acc_unst;
    int         n;

    evo_circuit_tester #(.NUM_VECTORS(4), .SETTLE_CYCLES(8), .SAMPLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_addr(vec_addr), .vec_data(vec_data),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .score(score), .unstable(unstable)
    );

    always #5 clk = ~clk;

    initial begin
        rom[0] = 3'b000;
        rom[1] = 3'b101;
        rom[2] = 3'b010;
        rom[3] = 3'b111;
    end

    always @(posedge clk) vec_data <= rom[vec_addr[1:0]];
    always @(posedge clk) tog <= ~tog;

    // mode 0: output = expected bit (in[0]); mode 1: constant 1; mode 2: toggles on vector 2
    assign dut_out = mode == 1 ? 1'b1 : (mode == 2 && dut_in == 2'b10) ? tog : dut_in[0];

    task automatic run(input int restart_at, input int abort_at, output int cyc);
        @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        acc_done = done; acc_busy = busy; acc_score = score; acc_unst = unstable;
        cyc = 0;
        while (!done && cyc < 1000 && cyc != abort_at) begin
            @(posedge clk);
            #1 cyc++;
            start = cyc == restart_at;
            for (int i = 0; i < 4; i++) if (cyc == 14 * i + 3) seen[i] = dut_in;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (vec_addr !== 3'd0) begin errors++; $display("FAIL reset_vec_addr got %0d want 0", vec_addr); end
        checks++; if (dut_in !== 2'b00) begin errors++; $display("FAIL reset_dut_in got %b want 00", dut_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (score !== 3'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if (unstable !== 3'd0) begin errors++; $display("FAIL reset_unstable got %0d want 0", unstable); end
    endtask

    task automatic test_match;
        mode = 0;
        run(-1, -1, n);
        checks++; if (acc_busy !== 1'b1) begin errors++; $display("FAIL match_busy_fetch got %b want 1", acc_busy); end
        checks++; if (n != 56) begin errors++; $display("FAIL match_latency got %0d want 56", n); end
        checks++; if (score !== 3'd4) begin errors++; $display("FAIL match_score got %0d want 4", score); end
        checks++; if (unstable !== 3'd0) begin errors++; $display("FAIL match_unstable got %0d want 0", unstable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL match_busy_end got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seen[i] !== 2'(i)) begin errors++; $display("FAIL match_dut_in%0d got %b want %b", i, seen[i], 2'(i)); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL match_done_hold got %b want 1", done); end
        checks++; if (dut_in !== 2'b11) begin errors++; $display("FAIL match_dut_in_hold got %b want 11", dut_in); end
    endtask

    task automatic test_const_one;
        mode = 1;
        run(-1, -1, n);
        checks++; if (score !== 3'd2) begin errors++; $display("FAIL const_score got %0d want 2", score); end
        checks++; if (unstable !== 3'd0) begin errors++; $display("FAIL const_unstable got %0d want 0", unstable); end
    endtask

    task automatic test_restart;
        mode = 0;
        run(20, -1, n);
        checks++; if (n != 56) begin errors++; $display("FAIL restart_latency got %0d want 56", n); end
        checks++; if (score !== 3'd4) begin errors++; $display("FAIL restart_score got %0d want 4", score); end
    endtask

    task automatic test_unstable;
        mode = 2;
        run(-1, -1, n);
        checks++; if (unstable !== 3'd1) begin errors++; $display("FAIL unstable_count got %0d want 1", unstable); end
        checks++; if (score !== 3'd3) begin errors++; $display("FAIL unstable_score got %0d want 3", score); end
    endtask

    task automatic test_back_to_back;
        mode = 0;
        run(-1, -1, n);
        checks++; if (acc_unst !== 3'd0) begin errors++; $display("FAIL b2b_clear_unstable got %0d want 0", acc_unst); end
        checks++; if (score !== 3'd4) begin errors++; $display("FAIL b2b_score1 got %0d want 4", score); end
        run(-1, -1, n);
        checks++; if (acc_done !== 1'b0) begin errors++; $display("FAIL b2b_clear_done got %b want 0", acc_done); end
        checks++; if (acc_score !== 3'd0) begin errors++; $display("FAIL b2b_clear_score got %0d want 0", acc_score); end
        checks++; if (n != 56) begin errors++; $display("FAIL b2b_latency got %0d want 56", n); end
        checks++; if (score !== 3'd4) begin errors++; $display("FAIL b2b_score2 got %0d want 4", score); end
    endtask

    task automatic test_reset_mid;
        mode = 0;
        run(-1, 47, n);
        checks++; if (dut_in !== 2'b11) begin errors++; $display("FAIL mid_pre_dut_in got %b want 11", dut_in); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got %b want 1", busy); end
        checks++; if (score !== 3'd3) begin errors++; $display("FAIL mid_pre_score got %0d want 3", score); end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_idle_done got %b want 0", done); end
        run(-1, -1, n);
        checks++; if (n != 56) begin errors++; $display("FAIL mid_rerun_latency got %0d want 56", n); end
        checks++; if (score !== 3'd4) begin errors++; $display("FAIL mid_rerun_score got %0d want 4", score); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_match();
        test_const_one();
        test_restart();
        test_unstable();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
